switch_egress_port: RTL and testbench
=====================================

// Module: switch_egress_port
// PURPOSE
//  Per-output egress stage; one instance per output of very_simple_switch.
//  Absorbs the switch's unthrottled data_out_valid/data_out words into a local FIFO.
//  Serialises each DATA_WIDTH word into LANE_WIDTH beats on a valid/ready link to the port PHY/MAC.
//  Words arriving while the FIFO is full are dropped and counted (the switch has no backpressure).
// PARAMETERS
//  DATA_WIDTH  64  switch word width; integer multiple of LANE_WIDTH, ratio >= 2
//  LANE_WIDTH  16  egress link beat width
//  DEPTH       16  egress FIFO entries; power of two, >= 2
//  CNT_WIDTH   16  drop counter width
// PORTS
//  clk        in   1                 clock
//  reset      in   1                 synchronous, active-high reset
//  in_valid   in   1                 word present from switch output (no ready; must be taken or dropped)
//  in_data    in   DATA_WIDTH        switch word
//  out_valid  out  1                 beat valid on egress link
//  out_ready  in   1                 egress sink accepts beat
//  out_data   out  LANE_WIDTH        current beat, MS lane first
//  out_last   out  1                 final beat of current word
//  occupancy  out  $clog2(DEPTH)+1   FIFO entries held (excludes the word in the serialiser)
//  drop_count out  CNT_WIDTH         saturating count of dropped words
// BEHAVIOUR
//  Reset: out_valid=0, out_last=0, out_data=0, occupancy=0, drop_count=0, FSM=IDLE, FIFO emptied.
//  Reset mid-word aborts it; the partial word is lost and no further beats are sent.
//  Write: in_valid && !full -> push. in_valid && full -> drop; drop_count+1, saturating at all-ones.
//  full is sampled pre-edge: a push while full is dropped even if a pop occurs in the same cycle.
//  NBEATS = DATA_WIDTH/LANE_WIDTH. Beat k (0-based) = in_data[DATA_WIDTH-1-k*LANE_WIDTH -: LANE_WIDTH].
//  FSM IDLE:  FIFO !empty -> pop head into shift reg, beat_cnt=0, go SEND. Otherwise stay.
//  FSM SEND:  out_valid=1; out_last=(beat_cnt==NBEATS-1).
//   out_valid && out_ready && !out_last -> shift one lane, beat_cnt+1.
//   Accepted last beat && FIFO !empty -> pop and load next word the same edge; stay SEND, no bubble.
//   Accepted last beat && FIFO empty -> IDLE.
//  AXI-style: while out_valid && !out_ready, out_data and out_last hold stable. out_valid never drops
//   before acceptance.
//  Latency: word pushed at edge N is seen in IDLE in cycle N+1, loaded at that edge, and its first
//   beat is valid in cycle N+2.
//  Throughput: sustained 1 beat/cycle with out_ready=1; input may burst at 1 word/cycle up to DEPTH.
//  Occupancy updates on push/pop edges; simultaneous push+pop leaves it unchanged.
//  out_data is 0 while out_valid=0.
// CONFIGURATION
//  SWITCH_EGRESS_DROP_CNT_EN defined: drop counter implemented as above.
//  Not defined: counter logic removed; drop_count tied to 0. Dropping behaviour is unchanged.
// STRUCTURE
//  switch_pkg: typedef enum logic {EGR_IDLE, EGR_SEND} egress_state_t;
//   function lane_qty(dw, lw) returning NBEATS.
//  Sub-module: the existing fifo (show-ahead, WIDTH=DATA_WIDTH, DEPTH), instantiated as u_egress_fifo.
//   Occupancy is derived locally from push/pop.
//  Serialiser FSM, shift register, beat counter and drop counter stay in this module.
//  Elaboration-time asserts: DATA_WIDTH % LANE_WIDTH == 0, NBEATS >= 2, DEPTH is a power of two.
// TESTING
//  1 Single word 64'h1111_2222_3333_4444, out_ready=1 -> beats 1111,2222,3333,4444 in cycles N+2..N+5;
//    out_last only on 4444.
//  2 Two words pushed on consecutive cycles, out_ready=1 -> 8 contiguous beats with no bubble;
//    occupancy peaks at 1.
//  3 out_ready=0 for 5 cycles mid-word (after beat 2222) -> 3333 held stable with out_valid=1,
//    then resumes in order.
//  4 out_ready=0, 18 back-to-back words -> 1 word in the serialiser, occupancy=16, drop_count=1;
//    the 18th word is never emitted.
//  5 FIFO full, in_valid high in the same cycle a pop occurs -> the word is dropped and drop_count
//    increments; occupancy drops to 15.
//  6 reset asserted mid-SEND -> next cycle out_valid=0, occupancy=0, drop_count=0; a fresh word
//    after reset is emitted correctly. Rerun 4 without SWITCH_EGRESS_DROP_CNT_EN -> drop_count stays 0.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and helpers for the switch egress path
//
// Contents:
//   egress_state_t  serialiser states (EGR_IDLE, EGR_SEND)
//   lane_qty()      number of lane beats per switch word
package switch_pkg;

    typedef enum logic {
        EGR_IDLE,
        EGR_SEND
    } egress_state_t;

    function automatic int lane_qty(input int dw, input int lw);
        return dw / lw;
    endfunction

endpackage

// File: rtl/switch_egress_port_fifo.sv
// rtl/switch_egress_port_fifo.sv - show-ahead synchronous FIFO
//
// Ports:
//   clk, reset   clock, synchronous active-high reset (empties the FIFO)
//   push         write push_data when not full (ignored when full)
//   push_data    WIDTH-bit write word
//   pop          discard head when not empty (ignored when empty)
//   pop_data     current head word, valid whenever empty=0
//   full, empty  status flags
module switch_egress_port_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/switch_egress_port.sv
// rtl/switch_egress_port.sv - per-output egress buffer and lane serialiser
//
// Absorbs unthrottled switch words into a FIFO (dropping when full) and sends
// each word as DATA_WIDTH/LANE_WIDTH beats, MS lane first, on a valid/ready link.
// Optional feature macro: SWITCH_EGRESS_DROP_CNT_EN (drop counter; else tied 0).
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     switch word present (no backpressure: taken or dropped)
//   in_data      switch word
//   out_valid    beat valid on egress link
//   out_ready    egress sink accepts beat
//   out_data     current beat (0 while out_valid=0)
//   out_last     final beat of the current word
//   occupancy    FIFO entries held, excluding the word in the serialiser
//   drop_count   saturating count of dropped words
module switch_egress_port
    import switch_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int NBEATS = lane_qty(DATA_WIDTH, LANE_WIDTH);
    localparam int BW     = $clog2(NBEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_chk_ratio
        $error("DATA_WIDTH must be an integer multiple of LANE_WIDTH");
    end
    if (NBEATS < 2) begin : g_chk_nbeats
        $error("DATA_WIDTH/LANE_WIDTH must be at least 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    egress_state_t         state;
    egress_state_t         state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         beat_cnt;
    logic                  beat_last;
    logic                  load;
    logic                  shift;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  push;
    logic                  pop;

    // full is the pre-edge flag, so a word arriving while full is dropped
    // even if the serialiser frees an entry on the same edge.
    assign push = in_valid && !fifo_full;
    assign pop  = load;

    switch_egress_port_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_egress_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign beat_last = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EGR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // On an accepted last beat the next word is loaded on the same edge so
    // back-to-back words leave without a bubble.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        out_valid = 1'b0;
        case (state)
            EGR_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = EGR_SEND;
                end
            end
            EGR_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!beat_last) begin
                        shift = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = EGR_IDLE;
                    end
                end
            end
            default: state_nxt = EGR_IDLE;
        endcase
    end

    assign out_last = (state == EGR_SEND) && beat_last;
    assign out_data = out_valid ? shreg[DATA_WIDTH-1 -: LANE_WIDTH] : '0;

    // The current beat always sits in the top lane of the shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            shreg    <= fifo_head;
            beat_cnt <= '0;
        end else if (shift) begin
            shreg    <= shreg << LANE_WIDTH;
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef SWITCH_EGRESS_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (in_valid && fifo_full && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_switch_egress_port.sv
// tb/tb_switch_egress_port.sv - scoreboard bench for switch_egress_port
module tb_switch_egress_port;

    localparam int DW    = 64;
    localparam int LW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

`ifdef SWITCH_EGRESS_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [LW-1:0] data;
        logic          last;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic [DW-1:0]            in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LW-1:0]            out_data;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [CW-1:0]            drop_count;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    switch_egress_port #(
        .DATA_WIDTH (DW),
        .LANE_WIDTH (LW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_drop(input int n);
        return CNT_EN ? 64'(n) : 64'd0;
    endfunction

    task automatic expect_word(input logic [DW-1:0] w);
        for (int k = 0; k < DW / LW; k++) begin
            beat_t b;
            b.data = w[DW-1-k*LW -: LW];
            b.last = (k == DW / LW - 1);
            exp_q.push_back(b);
        end
    endtask

    // Presents a word for one cycle; returns #1 after the capturing edge.
    task automatic push_word(input logic [DW-1:0] d, input bit keep);
        in_valid = 1'b1;
        in_data  = d;
        if (keep) expect_word(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        out_ready = r;
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks that a
    // stalled beat is held stable.
    logic          stall_prev = 1'b0;
    logic [LW-1:0] held_data;
    logic          held_last;
    int            max_occ = 0;
    beat_t         e;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(held_data));
                check("hold_last", 64'(out_last), 64'(held_last));
            end
            if (!out_valid) begin
                check("idle_data_zero", 64'(out_data), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_last", 64'(out_last), 64'(e.last));
                end
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    initial begin
        logic [DW-1:0] w;
        int            c;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);

        // 1: single word, latency N+2
        push_word(64'h1111_2222_3333_4444, 1'b1);
        @(negedge clk);
        check("t1_n1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_n2_valid", 64'(out_valid), 64'd1);
        check("t1_n2_data", 64'(out_data), 64'h1111);
        wait_drain("t1_drain", 20);

        // 2: two back-to-back words, no bubble, occupancy peak 1
        max_occ = 0;
        push_word(64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        push_word(64'h0102_0304_0506_0708, 1'b1);
        c = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) c++;
        end
        check("t2_contig_beats", 64'(c), 64'd8);
        @(negedge clk);
        check("t2_after_valid", 64'(out_valid), 64'd0);
        wait_drain("t2_drain", 20);
        check("t2_occ_peak", 64'(max_occ), 64'd1);

        // 3: stall after beat 2222
        push_word(64'h1111_2222_3333_4444, 1'b1);
        c = 0;
        while (!(out_valid && out_data == 16'h2222) && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t3_found_2222", 64'(out_data), 64'h2222);
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_valid", 64'(out_valid), 64'd1);
            check("t3_stall_data", 64'(out_data), 64'h3333);
            check("t3_stall_last", 64'(out_last), 64'd0);
        end
        set_ready(1'b1);
        wait_drain("t3_drain", 20);
        check("t3_drop", 64'(drop_count), 64'd0);

        // 4: 18 words with the sink stalled
        set_ready(1'b0);
        for (int k = 1; k <= 18; k++) begin
            w = {16'(16'hA000 + k), 16'(16'hB000 + k), 16'(16'hC000 + k), 16'(16'hD000 + k)};
            push_word(w, k <= 17);
        end
        @(negedge clk);
        check("t4_occ", 64'(occupancy), 64'd16);
        check("t4_drop", 64'(drop_count), exp_drop(1));
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_head_beat", 64'(out_data), 64'hA001);

        // 5: word arrives while full in the same cycle as a pop
        set_ready(1'b1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(out_valid && out_last) && c < 20);
        check("t5_at_last", 64'(out_data), 64'hD001);
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_occ", 64'(occupancy), 64'd15);
        check("t5_drop", 64'(drop_count), exp_drop(2));
        set_ready(1'b1);
        wait_drain("t5_drain", 200);

        // 6: reset in the middle of a word with another queued
        push_word(64'h5555_6666_7777_8888, 1'b1);
        push_word(64'h9999_AAAA_BBBB_CCCC, 1'b1);
        c = 0;
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t6_sending", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_occ", 64'(occupancy), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_data", 64'(out_data), 64'd0);
        push_word(64'h0123_4567_89AB_CDEF, 1'b1);
        wait_drain("t6_drain", 20);
        repeat (10) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
